// File: rtl/event_cap_pkg.sv
// Shared constants for the event capture monitor: default sizes and record field layout.
// A record is {ts, val, chg}, with chg in the least significant bits.
package event_cap_pkg;

  parameter int unsigned TS_W_DEFAULT  = 16;
  parameter int unsigned DEPTH_DEFAULT = 8;
  parameter int unsigned REC_W         = TS_W_DEFAULT + 6;

  parameter int unsigned CHG_OFF = 0;
  parameter int unsigned VAL_OFF = 3;
  parameter int unsigned TS_OFF  = 6;

  function automatic int unsigned rec_width(input int unsigned ts_w);
    return ts_w + 6;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Record FIFO: synchronous write, combinational head read, extra pointer bit for full/empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module event_fifo #(
  parameter int unsigned W     = event_cap_pkg::REC_W,
  parameter int unsigned DEPTH = event_cap_pkg::DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          wr_en, rd_en;

  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    rd_en   = pop_i && !empty_o;
    wr_en   = push_i && (!full_o || rd_en);
    wptr_d  = wr_en ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = rd_en ? rptr_q + PW'(1) : rptr_q;
    rdata_o = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is intentionally unreset; the head is masked by the top while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/event_capture_monitor.sv
// Synchronizes x/y/z, timestamps every change with a free-running counter and queues
// {ts, val, chg} records for a valid/ready consumer, flagging drops in a sticky ovf.
module event_capture_monitor #(
  parameter int unsigned TS_W  = event_cap_pkg::TS_W_DEFAULT,
  parameter int unsigned DEPTH = event_cap_pkg::DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            x,
  input  logic            y,
  input  logic            z,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [TS_W-1:0] rd_ts,
  output logic [2:0]      rd_val,
  output logic [2:0]      rd_chg,
  output logic            ovf,
  input  logic            clr_ovf
);

  import event_cap_pkg::*;

  localparam int unsigned RW = rec_width(TS_W);

  logic [2:0]      s1_q, s2_q, s3_q;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            ovf_q, ovf_d;
  logic            evt, pop, drop;
  logic            full, empty;
  logic [RW-1:0]   wrec, head;

  always_comb begin
    ts_d  = ts_q + TS_W'(1);
    evt   = en && (s2_q != s3_q);
    pop   = rd_ready && !empty;
    drop  = evt && full && !pop;
    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    wrec  = '0;
    wrec[TS_OFF +: TS_W] = ts_q;
    wrec[VAL_OFF +: 3]   = s2_q;
    wrec[CHG_OFF +: 3]   = s2_q ^ s3_q;
  end

  // s3 follows s2 even when disabled so re-enabling never reports stale changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      ts_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      s1_q  <= {x, y, z};
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      ts_q  <= ts_d;
      ovf_q <= ovf_d;
    end
  end

  event_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (evt),
    .pop_i   (pop),
    .wdata_i (wrec),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    rd_valid = !empty;
    ovf      = ovf_q;
    rd_ts    = empty ? '0 : head[TS_OFF +: TS_W];
    rd_val   = empty ? '0 : head[VAL_OFF +: 3];
    rd_chg   = empty ? '0 : head[CHG_OFF +: 3];
  end

endmodule
